// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: access-type encoding and FSM states.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    SB_B  = 3'b000,
    SB_H  = 3'b001,
    SB_W  = 3'b010,
    SB_BU = 3'b100,
    SB_HU = 3'b101
  } strb_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its priority pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt
);

  logic ptr;

  // A lone requester wins; on a tie the master holding the pointer wins
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ptr;
      default: gnt = 1'b0;
    endcase
  end

  // After every accepted grant, priority passes to the master that did not win
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~gnt;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one RAM port; each access takes
// IDLE -> ACCESS -> RESP, with alignment errors answered without touching RAM.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_strb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_strb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              ram_we,
  output logic [2:0]        ram_strb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e              state;
  logic                gnt_sel;
  logic                gnt_l;
  logic                we_l;
  strb_e               strb_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic                err_l;
  logic [DATA_W-1:0]   rdata_l;
  logic                ready_l;

  logic                sel_we;
  strb_e               sel_strb;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_err;
  logic                grant_now;
  logic                in_access;
  logic                resp_ok;

  assign grant_now = (state == IDLE) && (m0_req || m1_req);

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .advance (grant_now),
    .gnt     (gnt_sel)
  );

  // Select the winning master's fields and check alignment and legality
  always_comb begin
    sel_we    = gnt_sel ? m1_we    : m0_we;
    sel_strb  = strb_e'(gnt_sel ? m1_strb : m0_strb);
    sel_addr  = gnt_sel ? m1_addr  : m0_addr;
    sel_wdata = gnt_sel ? m1_wdata : m0_wdata;
    sel_err   = 1'b0;
    case (sel_strb)
      SB_B, SB_BU: sel_err = 1'b0;
      SB_H, SB_HU: sel_err = sel_addr[0];
      SB_W:        sel_err = (sel_addr[1:0] != 2'b00);
      default:     sel_err = 1'b1;
    endcase
    if (sel_we && ((sel_strb == SB_BU) || (sel_strb == SB_HU))) begin
      sel_err = 1'b1;
    end
  end

  // Access sequencer: latch the grant in IDLE, use the RAM in ACCESS, answer in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_l   <= 1'b0;
      we_l    <= 1'b0;
      strb_l  <= SB_B;
      addr_l  <= '0;
      wdata_l <= '0;
      err_l   <= 1'b0;
      rdata_l <= '0;
      ready_l <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            gnt_l   <= gnt_sel;
            we_l    <= sel_we;
            strb_l  <= sel_strb;
            addr_l  <= sel_addr;
            wdata_l <= sel_wdata;
            err_l   <= sel_err;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_l <= (we_l || err_l) ? '0 : ram_rdata;
          ready_l <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          rdata_l <= '0;
          ready_l <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port is only live in ACCESS; reset silences it even mid-access
  assign in_access = (state == ACCESS) && !reset;
  assign ram_we    = in_access && we_l && !err_l;
  assign ram_strb  = in_access ? strb_l  : 3'b000;
  assign ram_addr  = in_access ? addr_l  : '0;
  assign ram_wdata = in_access ? wdata_l : '0;

  // Response goes only to the granted master and is blanked during reset
  assign resp_ok  = ready_l && !reset;
  assign m0_ready = resp_ok && !gnt_l;
  assign m1_ready = resp_ok && gnt_l;
  assign m0_rdata = m0_ready ? rdata_l : '0;
  assign m1_rdata = m1_ready ? rdata_l : '0;
  assign m0_err   = m0_ready && err_l;
  assign m1_err   = m1_ready && err_l;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed little-endian RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_strb, m1_strb;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [2:0]  ram_strb;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int errors = 0;
  int checks = 0;
  int weCount = 0;

  logic [7:0] mem [0:255];
  logic [7:0] ra0, ra1, ra2, ra3;

  ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_strb(m0_strb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_strb(m1_strb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_strb(ram_strb), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model read path: extends by access type like the real memory
  always_comb begin
    ra0 = ram_addr;
    ra1 = ram_addr + 8'd1;
    ra2 = ram_addr + 8'd2;
    ra3 = ram_addr + 8'd3;
    case (ram_strb)
      3'b000:  ram_rdata = {{24{mem[ra0][7]}}, mem[ra0]};
      3'b001:  ram_rdata = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
      3'b010:  ram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
      3'b100:  ram_rdata = {24'h0, mem[ra0]};
      3'b101:  ram_rdata = {16'h0, mem[ra1], mem[ra0]};
      default: ram_rdata = 32'h0;
    endcase
  end

  // RAM model write path, also counting every write strobe
  always @(posedge clk) begin
    if (ram_we) begin
      weCount <= weCount + 1;
      case (ram_strb)
        3'b000: mem[ram_addr] <= ram_wdata[7:0];
        3'b001: begin
          mem[ram_addr]        <= ram_wdata[7:0];
          mem[ram_addr + 8'd1] <= ram_wdata[15:8];
        end
        3'b010: begin
          mem[ram_addr]        <= ram_wdata[7:0];
          mem[ram_addr + 8'd1] <= ram_wdata[15:8];
          mem[ram_addr + 8'd2] <= ram_wdata[23:16];
          mem[ram_addr + 8'd3] <= ram_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] memWord(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  // Issue one access from master m starting at a negedge in IDLE; returns the observations
  task automatic do_access(input bit m, input bit we, input logic [2:0] strb,
                           input logic [7:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output bit otherSeen, output bit busBusy);
    rd = '0; er = 1'b0; lat = 0; otherSeen = 1'b0; busBusy = 1'b0;
    if (!m) begin
      m0_req = 1'b1; m0_we = we; m0_strb = strb; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_strb = strb; m1_addr = addr; m1_wdata = wd;
    end
    while (lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (m ? m0_ready : m1_ready) otherSeen = 1'b1;
      if (m ? m1_ready : m0_ready) break;
    end
    rd = m ? m1_rdata : m0_rdata;
    er = m ? m1_err : m0_err;
    busBusy = ram_we || (ram_addr != 8'h0) || (ram_strb != 3'b0) || (ram_wdata != 32'h0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_strb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_strb = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    checks++; if ({m0_ready, m1_ready, m0_err, m1_err, ram_we} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {m0_ready, m1_ready, m0_err, m1_err, ram_we});
    checks++; if ({m0_rdata, m1_rdata, ram_wdata, ram_addr, ram_strb} !== '0)
      $display("[TB] FAIL reset_buses: got %h expected 0", {m0_rdata, m1_rdata, ram_wdata, ram_addr, ram_strb});
    if ({m0_ready, m1_ready, m0_err, m1_err, ram_we} !== 5'b0 ||
        {m0_rdata, m1_rdata, ram_wdata, ram_addr, ram_strb} !== '0) errors++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m0_ready, m1_ready, m0_err, m1_err, ram_we, m0_rdata, m1_rdata, ram_wdata, ram_addr, ram_strb} !== '0) begin
      errors++; $display("[TB] FAIL post_reset_outputs: got nonzero expected all 0");
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit oth, bus;
    do_access(1'b0, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd, er, lat, oth, bus);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("[TB] FAIL sw_resp: got err=%b rdata=%h expected 0/0", er, rd); end
    checks++; if (memWord(8'h10) !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_mem: got %h expected deadbeef", memWord(8'h10)); end
    checks++; if (oth !== 1'b0 || bus !== 1'b0) begin errors++; $display("[TB] FAIL sw_isolation: got other=%b bus=%b expected 0 0", oth, bus); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_one_cycle: got %b expected 0", m0_ready); end
    do_access(1'b0, 1'b0, 3'b010, 8'h10, 32'h0, rd, er, lat, oth, bus);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("[TB] FAIL lw_data: got %h err=%b expected deadbeef err=0", rd, er); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er; int lat; bit oth, bus;
    do_access(1'b0, 1'b0, 3'b000, 8'h13, 32'h0, rd, er, lat, oth, bus);
    checks++; if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin errors++; $display("[TB] FAIL lb_13: got %h expected ffffffde", rd); end
    do_access(1'b0, 1'b0, 3'b100, 8'h13, 32'h0, rd, er, lat, oth, bus);
    checks++; if (rd !== 32'h000000DE || er !== 1'b0) begin errors++; $display("[TB] FAIL lbu_13: got %h expected 000000de", rd); end
    do_access(1'b0, 1'b0, 3'b001, 8'h12, 32'h0, rd, er, lat, oth, bus);
    checks++; if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin errors++; $display("[TB] FAIL lh_12: got %h expected ffffdead", rd); end
    do_access(1'b0, 1'b0, 3'b101, 8'h12, 32'h0, rd, er, lat, oth, bus);
    checks++; if (rd !== 32'h0000DEAD || er !== 1'b0) begin errors++; $display("[TB] FAIL lhu_12: got %h expected 0000dead", rd); end
    do_access(1'b0, 1'b0, 3'b000, 8'h10, 32'h0, rd, er, lat, oth, bus);
    checks++; if (rd !== 32'hFFFFFFEF || er !== 1'b0) begin errors++; $display("[TB] FAIL lb_10: got %h expected ffffffef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit oth, bus; int weBefore;
    weBefore = weCount;
    do_access(1'b1, 1'b1, 3'b010, 8'h11, 32'h12345678, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL sw_misaligned: got err=%b rdata=%h expected 1/0", er, rd); end
    checks++; if (lat !== 2 || oth !== 1'b0) begin errors++; $display("[TB] FAIL err_latency: got lat=%0d other=%b expected 2/0", lat, oth); end
    do_access(1'b1, 1'b1, 3'b100, 8'h10, 32'h000000AA, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL store_lbu: got err=%b expected 1", er); end
    do_access(1'b1, 1'b1, 3'b001, 8'h13, 32'h0000AAAA, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL sh_misaligned: got err=%b expected 1", er); end
    checks++; if (weCount !== weBefore) begin errors++; $display("[TB] FAIL err_no_write: got %0d writes expected %0d", weCount, weBefore); end
    checks++; if (memWord(8'h10) !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL err_mem: got %h expected deadbeef", memWord(8'h10)); end
    do_access(1'b0, 1'b0, 3'b001, 8'h11, 32'h0, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL lh_misaligned: got err=%b rdata=%h expected 1/0", er, rd); end
    do_access(1'b0, 1'b0, 3'b011, 8'h10, 32'h0, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL strb_011: got err=%b rdata=%h expected 1/0", er, rd); end
    do_access(1'b0, 1'b0, 3'b010, 8'h12, 32'h0, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL lw_misaligned: got err=%b expected 1", er); end
    do_access(1'b1, 1'b0, 3'b001, 8'h12, 32'h0, rd, er, lat, oth, bus);
    checks++; if (er !== 1'b0 || rd !== 32'hFFFFDEAD) begin errors++; $display("[TB] FAIL m1_lh: got err=%b rdata=%h expected 0/ffffdead", er, rd); end
  endtask

  task automatic test_back_to_back();
    int nReady, firstAt, lastAt; bit spacingOk, stray, badData;
    nReady = 0; firstAt = -1; lastAt = -1; spacingOk = 1; stray = 0; badData = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_strb = 3'b010; m0_addr = 8'h10;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (m1_ready) stray = 1;
      if (m0_ready) begin
        if (lastAt >= 0 && (i - lastAt) != 3) spacingOk = 0;
        if (firstAt < 0) firstAt = i;
        lastAt = i;
        nReady++;
        if (m0_rdata !== 32'hDEADBEEF) badData = 1;
      end
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if (nReady !== 4 || firstAt !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d first=%0d expected 4 first=2", nReady, firstAt); end
    checks++; if (spacingOk !== 1'b1 || stray !== 1'b0 || badData !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_pattern: got spacing=%b stray=%b bad=%b expected 1 0 0", spacingOk, stray, badData);
    end
  endtask

  task automatic test_inflight();
    int lat; logic er;
    lat = 0; er = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_strb = 3'b010; m0_addr = 8'h30; m0_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    m0_addr = 8'h34; m0_wdata = 32'h22222222; m0_strb = 3'b011; m0_we = 1'b0;
    lat = 1;
    while (lat < 8) begin
      @(negedge clk);
      if (m0_ready) break;
      @(posedge clk);
      lat++;
    end
    er = m0_err;
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("[TB] FAIL inflight_resp: got lat=%0d err=%b expected 2/0", lat, er); end
    checks++; if (memWord(8'h30) !== 32'h11111111) begin errors++; $display("[TB] FAIL inflight_mem: got %h expected 11111111", memWord(8'h30)); end
  endtask

  task automatic test_round_robin();
    int seq [4]; int n; bit both, badData; logic [31:0] rd; logic er; int lat; bit oth, bus;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0; both = 0; badData = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_strb = 3'b010; m0_addr = 8'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_strb = 3'b100; m1_addr = 8'h11;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) both = 1;
      if ((m0_ready || m1_ready) && n < 4) begin
        seq[n] = m1_ready ? 1 : 0;
        if (m0_ready && m0_rdata !== 32'hDEADBEEF) badData = 1;
        if (m1_ready && m1_rdata !== 32'h000000BE) badData = 1;
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    checks++; if (n !== 4 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
      errors++; $display("[TB] FAIL rr_order: got n=%0d %0d%0d%0d%0d expected 4 0101", n, seq[0], seq[1], seq[2], seq[3]);
    end
    checks++; if (both !== 1'b0 || badData !== 1'b0) begin errors++; $display("[TB] FAIL rr_resp: got both=%b bad=%b expected 0 0", both, badData); end
    do_access(1'b0, 1'b0, 3'b010, 8'h10, 32'h0, rd, er, lat, oth, bus);
    n = -1;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (n < 0 && m1_ready) n = 1;
      if (n < 0 && m0_ready) n = 0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (n !== 1) begin errors++; $display("[TB] FAIL rr_pointer: got first winner %0d expected 1", n); end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] snap; int weBefore; bit sawReady; int n;
    snap = memWord(8'h20); weBefore = weCount; sawReady = 0;
    m0_req = 1'b1; m0_we = 1'b1; m0_strb = 3'b010; m0_addr = 8'h20; m0_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_access_bus: got we=%b addr=%h wdata=%h expected 0", ram_we, ram_addr, ram_wdata);
    end
    m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) sawReady = 1;
    end
    checks++; if (sawReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_ready: got ready expected none"); end
    checks++; if (weCount !== weBefore || memWord(8'h20) !== snap) begin
      errors++; $display("[TB] FAIL reset_no_write: got writes=%0d mem=%h expected %0d %h", weCount, memWord(8'h20), weBefore, snap);
    end
    n = -1;
    m0_req = 1'b1; m0_we = 1'b0; m0_strb = 3'b010; m0_addr = 8'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_strb = 3'b010; m1_addr = 8'h10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (n < 0 && m0_ready) n = 0;
      if (n < 0 && m1_ready) n = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL reset_pointer: got first winner %0d expected 0", n); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_inflight();
    test_round_robin();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
